// File: rtl/ghost_nav_control.sv
// ghost_nav_control: target-driven tile navigator for one ghost.
// Each step probes the four neighbours (one per cycle), picks a heading, and moves one tile.
`ifndef DIR_UP
`define DIR_UP    2'd0
`define DIR_RIGHT 2'd1
`define DIR_DOWN  2'd2
`define DIR_LEFT  2'd3
`endif

module ghost_nav_control #(
  parameter int         TILE        = 20,
  parameter int         COLS        = 32,
  parameter int         ROWS        = 24,
  parameter int         SPAWN_X     = 280,
  parameter int         SPAWN_Y     = 220,
  parameter int         SCATTER_COL = 31,
  parameter int         SCATTER_ROW = 0,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          step,
  input  logic [1:0]                    mode,
  input  logic [$clog2(COLS)-1:0]       target_col,
  input  logic [$clog2(ROWS)-1:0]       target_row,
  input  logic [ROWS*COLS-1:0]          tilemap_walls,
  output logic [$clog2(COLS*TILE)-1:0]  pos_x,
  output logic [$clog2(ROWS*TILE)-1:0]  pos_y,
  output logic [1:0]                    ghost_direction,
  output logic                          busy,
  output logic                          done
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int XW = $clog2(COLS*TILE);
  localparam int YW = $clog2(ROWS*TILE);
  localparam int IW = $clog2(ROWS*COLS);
  localparam int MW = (COLS > ROWS) ? COLS : ROWS;
  localparam int DW = 2*$clog2(MW) + 3;

  localparam logic [7:0]    SEED      = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [CW-1:0] COL_ZERO  = CW'(0);
  localparam logic [CW-1:0] COL_ONE   = CW'(1);
  localparam logic [CW-1:0] COL_MAX   = CW'(COLS-1);
  localparam logic [RW-1:0] ROW_ZERO  = RW'(0);
  localparam logic [RW-1:0] ROW_ONE   = RW'(1);
  localparam logic [RW-1:0] ROW_MAX   = RW'(ROWS-1);
  localparam logic [CW-1:0] HOME_COL  = CW'(SPAWN_X/TILE);
  localparam logic [RW-1:0] HOME_ROW  = RW'(SPAWN_Y/TILE);
  localparam logic [CW-1:0] SCAT_COL  = CW'(SCATTER_COL);
  localparam logic [RW-1:0] SCAT_ROW  = RW'(SCATTER_ROW);
  localparam logic [XW-1:0] STEP_X    = XW'(TILE);
  localparam logic [YW-1:0] STEP_Y    = YW'(TILE);
  localparam logic [XW-1:0] X_WRAPMAX = XW'((COLS-1)*TILE);

  // Probe-order indices; this order is also the tie-break priority.
  localparam logic [1:0] P_UP = 2'd0, P_LEFT = 2'd1, P_DOWN = 2'd2, P_RIGHT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_PROBE_UP, S_PROBE_LEFT, S_PROBE_DOWN, S_PROBE_RIGHT, S_DECIDE, S_MOVE
  } state_t;

  function automatic logic [1:0] idx_to_dir(input logic [1:0] idx);
    case (idx)
      P_UP:    return `DIR_UP;
      P_LEFT:  return `DIR_LEFT;
      P_DOWN:  return `DIR_DOWN;
      default: return `DIR_RIGHT;
    endcase
  endfunction

  function automatic logic [1:0] dir_to_idx(input logic [1:0] dir);
    case (dir)
      `DIR_UP:   return P_UP;
      `DIR_LEFT: return P_LEFT;
      `DIR_DOWN: return P_DOWN;
      default:   return P_RIGHT;
    endcase
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  state_t           state_r, state_next_s;
  logic [XW-1:0]    pos_x_r, mv_x_s;
  logic [YW-1:0]    pos_y_r, mv_y_s;
  logic [CW-1:0]    col_r, mv_col_s, ncol_s, tgt_col_r, mode_tgt_col_s;
  logic [RW-1:0]    row_r, mv_row_s, nrow_s, tgt_row_r, mode_tgt_row_s;
  logic [1:0]       dir_r, probe_idx_s, probe_dir_s, best_idx_r, rev_idx_s, rot_idx_s, dec_idx_s, dec_dir_s;
  logic [1:0]       prev_mode_r, eff_prev_s;
  logic [7:0]       lfsr_r;
  logic [3:0]       open_r, wall_r;
  logic [IW-1:0]    wall_idx_s;
  logic [DW-1:0]    best_dist_r, dist_s;
  logic signed [DW-1:0] dx_s, dy_s;
  logic             busy_r, done_r, primed_r, rev_flag_r, fright_r, have_best_r;
  logic             oob_s, nwall_s, cand_open_s, rev_ok_s, move_en_s;

  // Next-state sequencing: fixed probe walk, then decide and move.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE:        state_next_s = step ? S_PROBE_UP : S_IDLE;
      S_PROBE_UP:    state_next_s = S_PROBE_LEFT;
      S_PROBE_LEFT:  state_next_s = S_PROBE_DOWN;
      S_PROBE_DOWN:  state_next_s = S_PROBE_RIGHT;
      S_PROBE_RIGHT: state_next_s = S_DECIDE;
      S_DECIDE:      state_next_s = S_MOVE;
      default:       state_next_s = S_IDLE;
    endcase
  end

  // Effective target for the mode at acceptance; frightened ignores it.
  always_comb begin
    mode_tgt_col_s = target_col;
    mode_tgt_row_s = target_row;
    eff_prev_s     = primed_r ? prev_mode_r : mode;
    case (mode)
      2'd0:    begin mode_tgt_col_s = SCAT_COL; mode_tgt_row_s = SCAT_ROW; end
      2'd3:    begin mode_tgt_col_s = HOME_COL; mode_tgt_row_s = HOME_ROW; end
      default: begin mode_tgt_col_s = target_col; mode_tgt_row_s = target_row; end
    endcase
  end

  // Neighbour tile of the direction probed this cycle, its wall bit and distance.
  always_comb begin
    ncol_s = col_r;
    nrow_s = row_r;
    oob_s  = 1'b0;
    case (state_r)
      S_PROBE_LEFT:  probe_idx_s = P_LEFT;
      S_PROBE_DOWN:  probe_idx_s = P_DOWN;
      S_PROBE_RIGHT: probe_idx_s = P_RIGHT;
      default:       probe_idx_s = P_UP;
    endcase
    case (probe_idx_s)
      P_UP: begin
        if (row_r == ROW_ZERO) oob_s = 1'b1;
        else                   nrow_s = row_r - ROW_ONE;
      end
      P_DOWN: begin
        if (row_r == ROW_MAX) oob_s = 1'b1;
        else                  nrow_s = row_r + ROW_ONE;
      end
      P_LEFT:  ncol_s = (col_r == COL_ZERO) ? COL_MAX : col_r - COL_ONE;
      default: ncol_s = (col_r == COL_MAX) ? COL_ZERO : col_r + COL_ONE;
    endcase
    wall_idx_s  = IW'(nrow_s) * IW'(COLS) + IW'(ncol_s);
    nwall_s     = oob_s ? 1'b1 : tilemap_walls[wall_idx_s];
    probe_dir_s = idx_to_dir(probe_idx_s);
    cand_open_s = !nwall_s && (probe_dir_s != (dir_r ^ 2'b10));
    dx_s        = signed'(DW'(tgt_col_r)) - signed'(DW'(ncol_s));
    dy_s        = signed'(DW'(tgt_row_r)) - signed'(DW'(nrow_s));
    dist_s      = unsigned'(dx_s * dx_s + dy_s * dy_s);
  end

  // Heading choice: forced reverse, random rotation, best distance, dead-end reverse, or stay.
  always_comb begin
    rev_idx_s = dir_to_idx(dir_r ^ 2'b10);
    rev_ok_s  = !wall_r[rev_idx_s];
    rot_idx_s = lfsr_r[1:0];
    for (int k = 3; k >= 0; k--) begin
      rot_idx_s = open_r[2'(lfsr_r[1:0] + 2'(k))] ? 2'(lfsr_r[1:0] + 2'(k)) : rot_idx_s;
    end
    move_en_s = 1'b1;
    if (rev_flag_r && rev_ok_s) dec_idx_s = rev_idx_s;
    else if (|open_r)           dec_idx_s = fright_r ? rot_idx_s : best_idx_r;
    else if (rev_ok_s)          dec_idx_s = rev_idx_s;
    else begin
      dec_idx_s = best_idx_r;
      move_en_s = 1'b0;
    end
    dec_dir_s = idx_to_dir(dec_idx_s);
  end

  // Position one tile along the chosen heading, with horizontal tunnel wrap.
  always_comb begin
    mv_x_s   = pos_x_r;
    mv_y_s   = pos_y_r;
    mv_col_s = col_r;
    mv_row_s = row_r;
    case (dec_dir_s)
      `DIR_UP:   begin mv_y_s = pos_y_r - STEP_Y; mv_row_s = row_r - ROW_ONE; end
      `DIR_DOWN: begin mv_y_s = pos_y_r + STEP_Y; mv_row_s = row_r + ROW_ONE; end
      `DIR_LEFT: begin
        if (col_r == COL_ZERO) begin mv_x_s = X_WRAPMAX; mv_col_s = COL_MAX; end
        else begin mv_x_s = pos_x_r - STEP_X; mv_col_s = col_r - COL_ONE; end
      end
      default: begin
        if (col_r == COL_MAX) begin mv_x_s = '0; mv_col_s = COL_ZERO; end
        else begin mv_x_s = pos_x_r + STEP_X; mv_col_s = col_r + COL_ONE; end
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= S_IDLE;
    else        state_r <= state_next_s;
  end

  // Datapath: step latch, probe accumulation, decision commit and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos_x_r     <= XW'(SPAWN_X);
      pos_y_r     <= YW'(SPAWN_Y);
      col_r       <= HOME_COL;
      row_r       <= HOME_ROW;
      dir_r       <= `DIR_UP;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      lfsr_r      <= SEED;
      prev_mode_r <= 2'd0;
      primed_r    <= 1'b0;
      rev_flag_r  <= 1'b0;
      fright_r    <= 1'b0;
      have_best_r <= 1'b0;
      best_idx_r  <= P_UP;
      best_dist_r <= '0;
      open_r      <= 4'b0000;
      wall_r      <= 4'b0000;
      tgt_col_r   <= COL_ZERO;
      tgt_row_r   <= ROW_ZERO;
    end else begin
      busy_r <= (state_next_s != S_IDLE);
      done_r <= (state_next_s == S_MOVE);
      if (!primed_r) begin
        prev_mode_r <= mode;
        primed_r    <= 1'b1;
      end
      case (state_r)
        S_IDLE: begin
          if (step) begin
            prev_mode_r <= mode;
            rev_flag_r  <= (mode != eff_prev_s);
            fright_r    <= (mode == 2'd2);
            tgt_col_r   <= mode_tgt_col_s;
            tgt_row_r   <= mode_tgt_row_s;
            have_best_r <= 1'b0;
            open_r      <= 4'b0000;
            wall_r      <= 4'b0000;
          end
        end
        S_PROBE_UP, S_PROBE_LEFT, S_PROBE_DOWN, S_PROBE_RIGHT: begin
          open_r[probe_idx_s] <= cand_open_s;
          wall_r[probe_idx_s] <= nwall_s;
          if (cand_open_s && (!have_best_r || dist_s < best_dist_r)) begin
            have_best_r <= 1'b1;
            best_idx_r  <= probe_idx_s;
            best_dist_r <= dist_s;
          end
        end
        S_DECIDE: begin
          lfsr_r <= lfsr_next(lfsr_r);
          if (move_en_s) begin
            pos_x_r <= mv_x_s;
            pos_y_r <= mv_y_s;
            col_r   <= mv_col_s;
            row_r   <= mv_row_s;
            dir_r   <= dec_dir_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign pos_x           = pos_x_r;
  assign pos_y           = pos_y_r;
  assign ghost_direction = dir_r;
  assign busy            = busy_r;
  assign done            = done_r;

endmodule

// File: tb/tb_ghost_nav_control.sv
// Directed self-checking bench for ghost_nav_control: reset, corridor latency,
// tie-break, dead ends, mode-change reversal, tunnel wrap and frightened selection.
`ifndef DIR_UP
`define DIR_UP    2'd0
`define DIR_RIGHT 2'd1
`define DIR_DOWN  2'd2
`define DIR_LEFT  2'd3
`endif

module tb_ghost_nav_control;
  localparam int COLS = 32;
  localparam int ROWS = 24;
  localparam int TILE = 20;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 step = 1'b0;
  logic [1:0]           mode = 2'd1;
  logic [4:0]           target_col = 5'd0;
  logic [4:0]           target_row = 5'd0;
  logic [ROWS*COLS-1:0] tilemap_walls = '1;
  logic [9:0]           pos_x;
  logic [8:0]           pos_y;
  logic [1:0]           ghost_direction;
  logic                 busy;
  logic                 done;

  int n_checks = 0;
  int n_errors = 0;

  ghost_nav_control #(.LFSR_SEED(8'h01)) dut (
    .clk(clk), .reset(reset), .step(step), .mode(mode),
    .target_col(target_col), .target_row(target_row), .tilemap_walls(tilemap_walls),
    .pos_x(pos_x), .pos_y(pos_y), .ghost_direction(ghost_direction),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic open_tile(input int c, input int r);
    tilemap_walls[r*COLS + c] = 1'b0;
  endtask

  // One step accepted in IDLE; done expected exactly six cycles later.
  task automatic do_step(input string tag, input int ex_x, input int ex_y, input int ex_d);
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (4) tick();
    check_val({tag, "_busy"}, int'(busy), 1);
    check_val({tag, "_early_done"}, int'(done), 0);
    tick();
    check_val({tag, "_done"}, int'(done), 1);
    check_val({tag, "_x"}, int'(pos_x), ex_x);
    check_val({tag, "_y"}, int'(pos_y), ex_y);
    check_val({tag, "_dir"}, int'(ghost_direction), ex_d);
    tick();
    check_val({tag, "_idle"}, int'(busy), 0);
  endtask

  function automatic logic [7:0] ref_lfsr(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [1:0] ref_dir(input logic [1:0] idx);
    case (idx)
      2'd0:    return `DIR_UP;
      2'd1:    return `DIR_LEFT;
      2'd2:    return `DIR_DOWN;
      default: return `DIR_RIGHT;
    endcase
  endfunction

  initial begin
    logic       seen;
    logic [7:0] lf;
    logic [1:0] d, sel, rev_i;
    int         c, r;

    // Reset state
    tick();
    check_val("rst_x", int'(pos_x), 280);
    check_val("rst_y", int'(pos_y), 220);
    check_val("rst_dir", int'(ghost_direction), int'(`DIR_UP));
    check_val("rst_busy", int'(busy), 0);
    reset = 1'b1;
    tick();

    // Reset mid-probe with step still asserted aborts the step
    tilemap_walls = '1;
    open_tile(14, 10); open_tile(14, 11);
    step = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    check_val("abort_x", int'(pos_x), 280);
    check_val("abort_y", int'(pos_y), 220);
    check_val("abort_dir", int'(ghost_direction), int'(`DIR_UP));
    check_val("abort_busy", int'(busy), 0);
    check_val("abort_done", int'(done), 0);
    step = 1'b0;
    tick();
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    check_val("abort_no_residual", int'(seen), 0);

    // Straight corridor, chase target (14,0); a step during busy is ignored
    target_col = 5'd14; target_row = 5'd0;
    step = 1'b1; tick(); step = 1'b0;
    tick(); tick();
    step = 1'b1; tick(); step = 1'b0;
    tick();
    check_val("corr_c5_done", int'(done), 0);
    tick();
    check_val("corr_c6_done", int'(done), 1);
    check_val("corr_y", int'(pos_y), 200);
    check_val("corr_dir", int'(ghost_direction), int'(`DIR_UP));
    tick();
    check_val("corr_c7_done", int'(done), 0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    check_val("corr_ignored_step", int'(seen), 0);
    check_val("corr_y_hold", int'(pos_y), 200);

    // Tie-break: up and left equidistant -> up
    tilemap_walls = '1;
    open_tile(14, 9); open_tile(13, 10); open_tile(14, 10); open_tile(14, 11);
    target_col = 5'd13; target_row = 5'd9;
    do_step("tie_up", 280, 180, int'(`DIR_UP));
    // Left strictly closer -> left
    tilemap_walls = '1;
    open_tile(14, 8); open_tile(13, 9); open_tile(14, 9);
    target_col = 5'd12; target_row = 5'd8;
    do_step("tie_left", 260, 180, int'(`DIR_LEFT));
    // Only up open -> turn up
    tilemap_walls = '1;
    open_tile(13, 8); open_tile(13, 9);
    do_step("turn_up", 260, 160, int'(`DIR_UP));

    // Dead end heading up -> reverse down
    do_step("dead_end", 260, 180, int'(`DIR_DOWN));
    // Fully boxed -> no movement, done still pulses
    tilemap_walls = '1;
    open_tile(13, 9);
    do_step("boxed", 260, 180, int'(`DIR_DOWN));

    // Mode changes force reversal when the reverse tile is open
    tilemap_walls = '1;
    open_tile(13, 8); open_tile(13, 9); open_tile(13, 10);
    mode = 2'd0;
    do_step("to_scatter", 260, 160, int'(`DIR_UP));
    tilemap_walls = '1;
    open_tile(13, 7); open_tile(13, 8); open_tile(13, 9);
    mode = 2'd1; target_col = 5'd13; target_row = 5'd0;
    do_step("to_chase_rev", 260, 180, int'(`DIR_DOWN));
    tilemap_walls = '1;
    open_tile(13, 8); open_tile(13, 9); open_tile(13, 10);
    do_step("chase_no_rev", 260, 200, int'(`DIR_DOWN));

    // Tunnel: walk row 11 left from spawn, wrap from col 0 to col 31
    reset = 1'b0;
    tilemap_walls = '1;
    for (int i = 0; i <= 14; i++) open_tile(i, 11);
    open_tile(31, 11);
    tick();
    reset = 1'b1;
    tick();
    for (int k = 1; k <= 14; k++) do_step("walk", (14 - k) * TILE, 220, int'(`DIR_LEFT));
    do_step("tunnel", 620, 220, int'(`DIR_LEFT));

    // Frightened on an open field with seed 1 against a reference model
    reset = 1'b0;
    mode = 2'd2;
    tilemap_walls = '0;
    tick();
    reset = 1'b1;
    tick();
    lf = 8'h01; c = 14; r = 11; d = `DIR_UP;
    for (int s = 0; s < 8; s++) begin
      case (d)
        `DIR_UP:   rev_i = 2'd2;
        `DIR_DOWN: rev_i = 2'd0;
        `DIR_LEFT: rev_i = 2'd3;
        default:   rev_i = 2'd1;
      endcase
      sel = lf[1:0];
      if (sel == rev_i) sel = sel + 2'd1;
      d = ref_dir(sel);
      case (d)
        `DIR_UP:   r = r - 1;
        `DIR_DOWN: r = r + 1;
        `DIR_LEFT: c = (c == 0) ? COLS - 1 : c - 1;
        default:   c = (c == COLS - 1) ? 0 : c + 1;
      endcase
      lf = ref_lfsr(lf);
      do_step("fright", c * TILE, r * TILE, int'(d));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
